// File: rtl/cordic_vectoring_iter.sv
// Iterative CORDIC vectoring engine: one micro-rotation per clock, converts (x,y) to magnitude/phase.
// Optional macro CORDIC_GAIN_COMP_EN adds a COMP state that removes the ~1.6468 CORDIC gain.
`timescale 1ns/1ps

module sign #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] value_i,
  output logic             sign_ans
);
  assign sign_ans = ($signed(value_i) < $signed(WIDTH'(0)));
endmodule

module cordic_vectoring_iter #(
  parameter int WORD_WIDTH  = 16,
  parameter int ITERATIONS  = 12,
  parameter int ANGLE_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic signed [WORD_WIDTH-1:0]  x_in,
  input  logic signed [WORD_WIDTH-1:0]  y_in,
  output logic                          busy,
  output logic                          done,
  output logic        [WORD_WIDTH:0]    mag_out,
  output logic        [ANGLE_WIDTH-1:0] angle_out
);
  localparam int XW = WORD_WIDTH + 2;

  // S_OUT is the write-back cycle; S_DONE is the single cycle that shows done=1.
  typedef enum logic [2:0] {S_IDLE, S_ITER, S_COMP, S_OUT, S_DONE} state_t;

  state_t                  state_q;
  logic signed [XW-1:0]    x_q, y_q;
  logic [ANGLE_WIDTH-1:0]  z_q;
  logic [3:0]              i_q;
  logic                    zero_q;
  logic                    busy_q, done_q;
  logic [WORD_WIDTH:0]     mag_q;
  logic [ANGLE_WIDTH-1:0]  angle_q;

  logic signed [XW-1:0]    x_d, y_d, x_sh, y_sh;
  logic [ANGLE_WIDTH-1:0]  z_d, atan_v;
  logic signed [XW-1:0]    x_ext, y_ext, x_ld, y_ld;
  logic [ANGLE_WIDTH-1:0]  z_ld;
  logic                    y_neg;

  function automatic logic [15:0] atan_lut(input logic [3:0] idx);
    case (idx)
      4'd0:    atan_lut = 16'd8192;
      4'd1:    atan_lut = 16'd4836;
      4'd2:    atan_lut = 16'd2555;
      4'd3:    atan_lut = 16'd1297;
      4'd4:    atan_lut = 16'd651;
      4'd5:    atan_lut = 16'd326;
      4'd6:    atan_lut = 16'd163;
      4'd7:    atan_lut = 16'd81;
      4'd8:    atan_lut = 16'd41;
      4'd9:    atan_lut = 16'd20;
      4'd10:   atan_lut = 16'd10;
      4'd11:   atan_lut = 16'd5;
      4'd12:   atan_lut = 16'd3;
      4'd13:   atan_lut = 16'd1;
      4'd14:   atan_lut = 16'd1;
      default: atan_lut = 16'd0;
    endcase
  endfunction

  sign #(.WIDTH(XW)) u_sign (
    .value_i  (y_q),
    .sign_ans (y_neg)
  );

  // Two guard bits let -(-2^(W-1)) and the gain growth fit without overflow.
  always_comb begin
    x_ext = {{2{x_in[WORD_WIDTH-1]}}, x_in};
    y_ext = {{2{y_in[WORD_WIDTH-1]}}, y_in};
    if (x_in[WORD_WIDTH-1]) begin
      x_ld = -x_ext;
      y_ld = -y_ext;
      z_ld = {1'b1, {(ANGLE_WIDTH-1){1'b0}}};
    end else begin
      x_ld = x_ext;
      y_ld = y_ext;
      z_ld = '0;
    end
  end

  always_comb begin
    x_sh   = x_q >>> i_q;
    y_sh   = y_q >>> i_q;
    atan_v = ANGLE_WIDTH'(atan_lut(i_q));
    if (!y_neg) begin
      x_d = x_q + y_sh;
      y_d = y_q - x_sh;
      z_d = z_q + atan_v;
    end else begin
      x_d = x_q - y_sh;
      y_d = y_q + x_sh;
      z_d = z_q - atan_v;
    end
  end

`ifdef CORDIC_GAIN_COMP_EN
  logic signed [XW-1:0] x_comp;
  assign x_comp = (x_q >>> 1) + (x_q >>> 3) - (x_q >>> 6) - (x_q >>> 9) - (x_q >>> 13);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      i_q     <= '0;
      zero_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      mag_q   <= '0;
      angle_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            x_q     <= x_ld;
            y_q     <= y_ld;
            z_q     <= z_ld;
            i_q     <= '0;
            zero_q  <= (x_in == '0) && (y_in == '0);
            busy_q  <= 1'b1;
            state_q <= S_ITER;
          end
        end
        S_ITER: begin
          x_q <= x_d;
          y_q <= y_d;
          z_q <= z_d;
          i_q <= i_q + 4'd1;
          if (i_q == 4'(ITERATIONS - 1)) begin
`ifdef CORDIC_GAIN_COMP_EN
            state_q <= S_COMP;
`else
            state_q <= S_OUT;
`endif
          end
        end
`ifdef CORDIC_GAIN_COMP_EN
        S_COMP: begin
          x_q     <= x_comp;
          state_q <= S_OUT;
        end
`endif
        S_OUT: begin
          mag_q   <= zero_q ? '0 : x_q[WORD_WIDTH:0];
          angle_q <= zero_q ? '0 : z_q;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_DONE;
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign mag_out   = mag_q;
  assign angle_out = angle_q;
endmodule
